// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with counter-based occupancy, registered read port,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 2,
    parameter int AF_LEVEL = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              pop,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_ok, pop_ok;

    // Acceptance looks only at the registered count, so no input reaches an output combinationally.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop_ok) begin
            head_d      = head_q + 1'b1;
            out_data_d  = mem[head_q];
            out_valid_d = 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A new error event in the same cycle as clr_err keeps the flag set.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_sync_fifo_param;
    localparam int W  = 32;
    localparam int AW = 2;
    localparam int D  = 1 << AW;

    logic          clk;
    logic          rst;
    logic          push;
    logic [W-1:0]  in_data;
    logic          pop;
    logic          clr_err;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_ovf;
    logic         m_unf;
    logic         m_push_acc;

    sync_fifo_param #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .in_data(in_data), .pop(pop),
        .clr_err(clr_err), .out_data(out_data), .out_valid(out_valid),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic model_reset();
        exp_q.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
    task automatic step(input logic p, input logic [W-1:0] d, input logic q, input logic c);
        bit was_full, was_empty, pop_acc, push_acc;
        push = p; in_data = d; pop = q; clr_err = c;
        @(posedge clk);
        was_full  = (exp_q.size() == D);
        was_empty = (exp_q.size() == 0);
        pop_acc   = q && !was_empty;
        push_acc  = p && (!was_full || pop_acc);
        if (pop_acc) begin
            m_out   = exp_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (push_acc) exp_q.push_back(d);
        if (p && !push_acc) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (q && was_empty) m_unf = 1'b1;
        else if (c) m_unf = 1'b0;
        m_push_acc = push_acc;
        #1;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; in_data = '0;
        model_reset();
        #3;
        n_checks++;
        if ({count, empty, almost_empty, full, almost_full} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d e=%b ae=%b f=%b af=%b, required 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        n_checks++;
        if ({out_valid, overflow, underflow} !== 3'b000 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ov=%b of=%b uf=%b data=%h, required 0 0 0 0",
                     out_valid, overflow, underflow, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            step(1'b1, W'(32'hA0 + i), 1'b0, 1'b0);
            n_checks++;
            if (count !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_count[%0d]: got %0d, required %0d", i, count, i + 1);
            end
            n_checks++;
            if (almost_full !== (i + 1 >= D - 1) || full !== (i + 1 == D)) begin
                n_fail++;
                $display("FAIL fill_flags[%0d]: af=%b f=%b, required %b %b", i, almost_full, full,
                         (i + 1 >= D - 1), (i + 1 == D));
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_overflow: of=%b e=%b, required 0 0", overflow, empty);
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 32'hFF, 1'b0, 1'b0);
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set: count=%0d of=%b, required 4 1", count, overflow);
        end
        step(1'b0, '0, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: of=%b, required 1", overflow);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        n_checks++;
        if (overflow !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_clear: of=%b count=%0d, required 0 4", overflow, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < D + 1; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (i < D) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== W'(32'hA0 + i)) begin
                    n_fail++;
                    $display("FAIL drain_data[%0d]: valid=%b data=%h, required 1 %h", i, out_valid,
                             out_data, 32'hA0 + i);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0 || out_data !== 32'hA3 || underflow !== 1'b1 || empty !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drain_underflow: valid=%b data=%h uf=%b e=%b, required 0 a3 1 1",
                             out_valid, out_data, underflow, empty);
                end
            end
        end
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < D; i++) step(1'b1, W'(32'hB0 + i), 1'b0, 1'b0);
        step(1'b1, 32'hC0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hB0) begin
            n_fail++;
            $display("FAIL simul_full: count=%0d of=%b valid=%b data=%h, required 4 0 1 b0",
                     count, overflow, out_valid, out_data);
        end
        for (int i = 0; i < D; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            n_checks++;
            if (out_data !== m_out || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL simul_drain[%0d]: data=%h valid=%b, required %h 1", i, out_data,
                         out_valid, m_out);
            end
        end
        step(1'b1, 32'hD0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 3'd1 || out_valid !== 1'b0 || underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_empty: count=%0d valid=%b uf=%b, required 1 0 1", count, out_valid,
                     underflow);
        end
        step(1'b0, '0, 1'b1, 1'b1);
        n_checks++;
        if (out_data !== 32'hD0 || underflow !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_after: data=%h uf=%b e=%b, required d0 0 1", out_data, underflow, empty);
        end
    endtask

    task automatic test_wrap_random();
        logic [W-1:0] seq = 32'h1000;
        logic [W-1:0] next_rd = 32'h1000;
        int cycles = 0;
        while ((seq - 32'h1000 < 3 * D || exp_q.size() != 0) && cycles < 400) begin
            logic p, q;
            p = (seq - 32'h1000 < 3 * D) ? 1'($urandom_range(0, 1)) : 1'b0;
            q = ($urandom_range(0, 2) != 0);
            step(p, seq, q, 1'b1);
            if (m_push_acc) seq++;
            cycles++;
            n_checks++;
            if (out_valid !== m_valid || (m_valid && out_data !== m_out) || count !== 3'(exp_q.size())) begin
                n_fail++;
                $display("FAIL wrap_data[%0d]: valid=%b data=%h count=%0d, required %b %h %0d", cycles,
                         out_valid, out_data, count, m_valid, m_out, exp_q.size());
            end
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_data !== next_rd) begin
                    n_fail++;
                    $display("FAIL wrap_order: data=%h, required %h", out_data, next_rd);
                end
                next_rd++;
            end
            n_checks++;
            if (full !== (exp_q.size() == D) || empty !== (exp_q.size() == 0) ||
                almost_full !== (exp_q.size() >= D - 1) || almost_empty !== (exp_q.size() <= 1) ||
                overflow !== m_ovf || underflow !== m_unf || count > 3'(D)) begin
                n_fail++;
                $display("FAIL wrap_flags[%0d]: f=%b e=%b af=%b ae=%b of=%b uf=%b count=%0d, model size %0d of=%b uf=%b",
                         cycles, full, empty, almost_full, almost_empty, overflow, underflow, count,
                         exp_q.size(), m_ovf, m_unf);
            end
        end
        n_checks++;
        if (next_rd !== 32'h1000 + 3 * D) begin
            n_fail++;
            $display("FAIL wrap_total: read up to %h, required %h", next_rd, 32'h1000 + 3 * D);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < D + 1; i++) step(1'b1, W'(32'hE0 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (count !== 3'd3 || overflow !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL async_setup: count=%0d of=%b valid=%b, required 3 1 1", count, overflow, out_valid);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (count !== 3'd0 || full !== 1'b0 || empty !== 1'b1 || out_valid !== 1'b0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: count=%0d f=%b e=%b valid=%b of=%b uf=%b, required 0 0 1 0 0 0",
                     count, full, empty, out_valid, overflow, underflow);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_after: valid=%b uf=%b count=%0d, required 0 1 0", out_valid, underflow, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_simultaneous();
        test_wrap_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the general-purpose buffer between producer and consumer stages in the datapath. Width and depth are configurable. All DEPTH entries are usable, with occupancy tracked by a counter rather than inferred from the pointers. Adds almost-full/almost-empty thresholds, an occupancy count, a registered read port with a valid strobe, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 32, data width in bits
- ADDR_W, 2, pointer width; DEPTH = 1<<ADDR_W (minimum ADDR_W = 1)
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- push  in  1  write request; in_data is sampled on the same edge
- in_data  in  WIDTH  write data
- pop  in  1  read request
- clr_err  in  1  synchronous clear of overflow/underflow
- out_data  out  WIDTH  registered read data
- out_valid  out  1  high for one cycle after an accepted pop
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  sticky; a push was dropped
- underflow  out  1  sticky; a pop was rejected

## Operation
**Storage.**
- DEPTH x WIDTH memory with head (read) and tail (write) pointers, each ADDR_W bits.
- Pointers wrap modulo DEPTH with natural binary rollover.
- Memory contents are not reset.

**Accept rules**, evaluated on the registered count at the clock edge:
- A push is accepted when !full, or when full and pop is also accepted in the same cycle.
- A pop is accepted when !empty. There is no fall-through: a push and pop together on empty accepts the push and rejects the pop.

**Accepted push.** mem[tail] <= in_data; tail <= tail+1.

**Accepted pop.** out_data <= mem[head]; head <= head+1; out_valid <= 1.

**No accepted pop.**
- out_valid <= 0.
- out_data holds its previous value. It is not zeroed.

**Count update.**
- count <= count + (push accepted) - (pop accepted).
- Simultaneous accepted push and pop leaves count unchanged.

**Flags.** full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free with respect to push/pop.

**Errors.**
- overflow <= 1 when push is high and the push is not accepted.
- underflow <= 1 when pop is high and empty.
- Both stay set until clr_err.
- If clr_err and a new error event occur in the same cycle, the set wins.

**Reset (rst low, asynchronous).**
- head, tail and count go to 0.
- out_data goes to 0; out_valid, overflow and underflow go to 0.
- Resulting outputs: empty=1, almost_empty=1, full=0, almost_full=0 (for AF_LEVEL >= 1).
- Reset mid-operation discards all contents immediately.
- The first push after rst rises is accepted on the first rising clk edge.

## Timing
- Write-to-read latency: data pushed at edge N is poppable at edge N+1. It appears on out_data after that pop edge.
- Read latency is 1 cycle: pop sampled at edge N gives out_data/out_valid valid after edge N, for the cycle N..N+1.
- Flags and count update one edge after the causing push/pop.
- There is no combinational path from push/pop to any output.
- Back-to-back push and pop every cycle are sustained at full throughput at any occupancy 0 < count < DEPTH. The same holds at count == DEPTH. At count == 0, only the push is accepted.

## Test plan
- **Reset then fill:** rst low, release, push 0xA0..0xA3 on 4 cycles (ADDR_W=2) -> count 1,2,3,4; full=1 after 4th edge; almost_full=1 after 3rd edge; overflow=0.
- **Overflow:** from full, push 0xFF alone -> dropped; count stays 4; overflow=1 and stays 1; clr_err for one cycle -> overflow=0.
- **Drain order and underflow:** from full, pop 5 cycles -> out_data 0xA0,0xA1,0xA2,0xA3 with out_valid=1 on the first four; fifth pop gives out_valid=0, out_data holds 0xA3, underflow=1, empty=1.
- **Wrap-around:** push/pop interleaved for 3*DEPTH items with an incrementing pattern -> every item is read in order; count never exceeds DEPTH; pointers wrap without loss.
- **Simultaneous push and pop:**
  - at full -> both accepted, count stays 4, overflow stays 0;
  - at empty -> push accepted, count becomes 1, out_valid=0, underflow=1.
- **Async reset mid-stream:** with count=3, assert rst between edges -> count, full, out_valid and errors clear immediately, without waiting for a clock edge; after release, pop returns nothing (underflow=1).
